// File: rtl/control_unit.sv
// Hardwired fetch/execute control sequencer for the datapath.
// Steps through T0..T6 and decodes IR into bus selects, load enables and ALU op selects.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MDRout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic [15:0] Rout,
    output logic        MARin,
    output logic        MDRin,
    output logic        PCin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin,
    output logic        Read,
    output logic        IncPC,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        MUL,
    output logic        Run,
    output logic [3:0]  State
);

    // state  | meaning
    // RESET  | held by clr=0; all strobes off
    // T0     | PC to MAR, Z <= PC+1
    // T1     | PC <= Z, memory read into MDR
    // T2     | MDR to IR; branch on opcode
    // T3     | Rb to Y
    // T4     | Rc through ALU into Z
    // T5     | Zlow to Ra (ALU ops) or LO (MUL)
    // T6     | Zhigh to HI (MUL only)
    // HALT   | parked until clr=0
    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_HALT  = 4'd8
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t      r_state;
    logic [4:0]  w_op;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic        w_is_alu;
    logic        w_is_mul;
    logic        w_is_halt;
    logic        w_unused;

    function automatic logic [15:0] f_onehot(input logic [3:0] idx);
        f_onehot = 16'h0001 << idx;
    endfunction

    assign w_op      = IR[31:27];
    assign w_ra      = IR[26:23];
    assign w_rb      = IR[22:19];
    assign w_rc      = IR[18:15];
    assign w_is_alu  = (w_op == OP_ADD) || (w_op == OP_SUB) ||
                       (w_op == OP_AND) || (w_op == OP_OR);
    assign w_is_mul  = (w_op == OP_MUL);
    assign w_is_halt = (w_op == OP_HALT);
    // Low IR bits hold immediates for other units and are not decoded here.
    assign w_unused  = ^IR[14:0];

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= S_RESET;
        end else begin
            case (r_state)
                S_RESET: r_state <= S_T0;
                S_T0:    r_state <= S_T1;
                S_T1:    r_state <= S_T2;
                S_T2: begin
                    if (w_is_halt)
                        r_state <= S_HALT;
                    else if (w_is_alu || w_is_mul)
                        r_state <= S_T3;
                    else
                        r_state <= S_T0;
                end
                S_T3:    r_state <= S_T4;
                S_T4:    r_state <= S_T5;
                S_T5:    r_state <= w_is_mul ? S_T6 : S_T0;
                S_T6:    r_state <= S_T0;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_RESET;
            endcase
        end
    end

    // Outputs are a pure decode of the state register and IR.
    always_comb begin
        PCout    = 1'b0;
        MDRout   = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        Rout     = 16'h0000;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        PCin     = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Rin      = 16'h0000;
        Read     = 1'b0;
        IncPC    = 1'b0;
        ADD      = 1'b0;
        SUB      = 1'b0;
        AND      = 1'b0;
        OR       = 1'b0;
        MUL      = 1'b0;
        case (r_state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Rout = f_onehot(w_rb);
                Yin  = 1'b1;
            end
            S_T4: begin
                Rout = f_onehot(w_rc);
                Zin  = 1'b1;
                ADD  = (w_op == OP_ADD);
                SUB  = (w_op == OP_SUB);
                AND  = (w_op == OP_AND);
                OR   = (w_op == OP_OR);
                MUL  = w_is_mul;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (w_is_mul)
                    LOin = 1'b1;
                else
                    Rin = f_onehot(w_ra);
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign Run   = (r_state != S_RESET) && (r_state != S_HALT);
    assign State = r_state;

endmodule
